// File: rtl/dmem_pkg.sv
// Shared constants and sequencer state type for the data-memory sort block.
package dmem_pkg;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int DMEM_DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_B, CMP, WR_A, WR_B, NEXT, FIN
  } sort_state_t;
endpackage

// File: rtl/dmem_port_mux.sv
// Data-memory port select: CPU when idle, sort sequencer when busy.
module dmem_port_mux #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          sel_ctl,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_we,
  input  logic [AW-1:0] ctl_addr,
  input  logic [DW-1:0] ctl_wdata,
  input  logic          ctl_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we
);
  assign mem_addr  = sel_ctl ? ctl_addr  : cpu_addr;
  assign mem_wdata = sel_ctl ? ctl_wdata : cpu_wdata;
  assign mem_we    = sel_ctl ? ctl_we    : cpu_we;
endmodule

// File: rtl/dmem_sort_ctrl.sv
// In-place ascending bubble sort over a wrapping window of data memory.
module dmem_sort_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  swaps,
  output logic              cpu_stall,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  import dmem_pkg::*;

  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  sort_state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] p_q, p_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              swp_q, swp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  swaps_q, swaps_d;

  logic [LEN_W-1:0]  len_c;
  logic [ADDR_W-1:0] addr_lo, addr_hi;
  logic [ADDR_W-1:0] ctl_addr;
  logic [DATA_W-1:0] ctl_wdata;
  logic              ctl_we;

  assign len_c   = (len > MAX_LEN) ? MAX_LEN : len;
  assign addr_lo = base_q + i_q;
  assign addr_hi = addr_lo + ONE;

  always_comb begin
    ctl_addr  = addr_lo;
    ctl_wdata = b_q;
    ctl_we    = 1'b0;
    case (state_q)
      RD_B: ctl_addr = addr_hi;
      WR_A: ctl_we = 1'b1;
      WR_B: begin
        ctl_addr  = addr_hi;
        ctl_wdata = a_q;
        ctl_we    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    i_d     = i_q;
    p_d     = p_q;
    a_d     = a_q;
    b_d     = b_q;
    swp_d   = swp_q;
    swaps_d = swaps_q;
    case (state_q)
      IDLE: if (start) begin
        base_d  = base;
        swaps_d = '0;
        if (len_c <= LEN_W'(1)) begin
          state_d = FIN;
        end else begin
          p_d     = ADDR_W'(len_c - LEN_W'(1));
          i_d     = '0;
          swp_d   = 1'b0;
          state_d = RD_A;
        end
      end
      RD_A: begin
        a_d     = mem_rdata;
        state_d = RD_B;
      end
      RD_B: begin
        b_d     = mem_rdata;
        state_d = CMP;
      end
      // Equal words stay put, which keeps the sort stable.
      CMP:  state_d = (a_q > b_q) ? WR_A : NEXT;
      WR_A: state_d = WR_B;
      WR_B: begin
        swaps_d = swaps_q + CNT_W'(1);
        swp_d   = 1'b1;
        state_d = NEXT;
      end
      NEXT: begin
        if ((i_q + ONE) < p_q) begin
          i_d     = i_q + ONE;
          state_d = RD_A;
        end else if (!swp_q || p_q == ONE) begin
          state_d = FIN;
        end else begin
          p_d     = p_q - ONE;
          i_d     = '0;
          swp_d   = 1'b0;
          state_d = RD_A;
        end
      end
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      i_q     <= '0;
      p_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      swp_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      swaps_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      i_q     <= i_d;
      p_q     <= p_d;
      a_q     <= a_d;
      b_q     <= b_d;
      swp_q   <= swp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      swaps_q <= swaps_d;
    end
  end

  assign busy      = busy_q;
  assign cpu_stall = busy_q;
  assign done      = done_q;
  assign swaps     = swaps_q;

  dmem_port_mux #(
    .AW(ADDR_W),
    .DW(DATA_W)
  ) u_mux (
    .sel_ctl  (busy_q),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_we   (cpu_we),
    .ctl_addr (ctl_addr),
    .ctl_wdata(ctl_wdata),
    .ctl_we   (ctl_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we)
  );
endmodule
